// File: rtl/button_edge_irq_ctrl_pkg.sv
// Shared definitions for the push-button edge/IRQ controller.
// Holds the Avalon register offsets, the MODE register bit positions
// and the MODE reset value (capture presses only).
package btn_ctrl_pkg;

  // Word offsets of the four registers on the slave port
  typedef enum logic [1:0] {
    ADDR_DATA    = 2'd0,
    ADDR_IRQMASK = 2'd1,
    ADDR_EDGECAP = 2'd2,
    ADDR_MODE    = 2'd3
  } reg_addr_e;

  // MODE register bit positions
  localparam int MODE_PRESS   = 0;
  localparam int MODE_RELEASE = 1;

  // Out of reset only press edges are captured
  localparam logic [1:0] MODE_RESET = 2'b01;

endpackage : btn_ctrl_pkg

// File: rtl/button_edge_irq_ctrl_if.sv
// Avalon-MM slave bus bundle for the push-button controller.
// Signals:
//   address    - word offset of the register being accessed
//   chipselect - slave select
//   write_n    - active-low write strobe, qualified by chipselect
//   writedata  - write data
//   readdata   - registered read data from the slave
// Modports: master (CPU side) and slave (controller side).
interface button_edge_irq_ctrl_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

endinterface : button_edge_irq_ctrl_if

// File: rtl/button_edge_irq_ctrl_debounce.sv
// Single-button conditioner: 2-flop synchroniser, debounce counter and
// accepted (stable) level, plus 1-cycle rise/fall pulses on that level.
// Ports:
//   clk, reset_n - clock and asynchronous active-low reset
//   din          - raw asynchronous button pin
//   level        - debounced stable level
//   rise, fall   - 1-cycle pulses when the stable level goes 0->1 / 1->0
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit IDLE_LEVEL      = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] TERMINAL = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic          stable_dly_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Synchroniser, counter and level all restart from the idle level so a
  // reset mid-debounce forces a full new window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q      <= IDLE_LEVEL;
      sync2_q      <= IDLE_LEVEL;
      stable_q     <= IDLE_LEVEL;
      stable_dly_q <= IDLE_LEVEL;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= din;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      cnt_q        <= cnt_d;
    end
  end

  // Any return to the stable level clears the count; reaching terminal
  // count accepts the new level and clears on the same cycle, so the
  // counter never wraps.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == TERMINAL) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign level = stable_q;
  assign rise  = stable_q & ~stable_dly_q;
  assign fall  = ~stable_q & stable_dly_q;

endmodule : button_debounce

// File: rtl/button_edge_irq_ctrl.sv
// Push-button controller with Avalon-MM slave register file.
// Debounces each button, captures press/release edges into a W1C
// edge-capture register and raises a maskable level interrupt.
// Ports:
//   clk, reset_n - clock and asynchronous active-low reset
//   bus          - Avalon-MM slave (address/chipselect/write_n/writedata/readdata)
//   in_port      - raw asynchronous button pins
//   irq          - level interrupt, active high
// Registers: 0 DATA (RO), 1 IRQMASK, 2 EDGECAPTURE (W1C), 3 MODE.
module button_edge_irq_ctrl
  import btn_ctrl_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit IDLE_LEVEL      = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  button_edge_irq_ctrl_if.slave         bus,
  input  logic [WIDTH-1:0]              in_port,
  output logic                          irq
);

  logic [WIDTH-1:0] level, rise, fall;
  logic [WIDTH-1:0] press_evt, release_evt, edge_evt;

  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [1:0]       mode_q, mode_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q, irq_d;
  logic             wr_en;
  logic             unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .IDLE_LEVEL      (IDLE_LEVEL)
    ) u_debounce (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (in_port[i]),
      .level   (level[i]),
      .rise    (rise[i]),
      .fall    (fall[i])
    );
  end

  // A press is the stable level leaving idle, a release is it returning
  assign press_evt   = IDLE_LEVEL ? fall : rise;
  assign release_evt = IDLE_LEVEL ? rise : fall;
  assign edge_evt    = (press_evt   & {WIDTH{mode_q[MODE_PRESS]}}) |
                       (release_evt & {WIDTH{mode_q[MODE_RELEASE]}});

  // Only the low bits of writedata are stored; the rest are don't-care
  assign unused_wdata = ^bus.writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      mode_q     <= MODE_RESET;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      mode_q     <= mode_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  // Register writes, W1C clear then edge set so a same-cycle edge wins.
  // Read mux samples current state, i.e. the value before any write.
  always_comb begin
    wr_en      = bus.chipselect & ~bus.write_n;
    irqmask_d  = irqmask_q;
    mode_d     = mode_q;
    edgecap_d  = edgecap_q;
    readdata_d = '0;

    if (wr_en) begin
      case (reg_addr_e'(bus.address))
        ADDR_IRQMASK: irqmask_d = bus.writedata[WIDTH-1:0];
        ADDR_EDGECAP: edgecap_d = edgecap_q & ~bus.writedata[WIDTH-1:0];
        ADDR_MODE:    mode_d    = bus.writedata[1:0];
        default:      ;
      endcase
    end
    edgecap_d = edgecap_d | edge_evt;

    case (reg_addr_e'(bus.address))
      ADDR_DATA:    readdata_d[WIDTH-1:0] = level;
      ADDR_IRQMASK: readdata_d[WIDTH-1:0] = irqmask_q;
      ADDR_EDGECAP: readdata_d[WIDTH-1:0] = edgecap_q;
      ADDR_MODE:    readdata_d[1:0]       = mode_q;
      default:      readdata_d            = '0;
    endcase

    irq_d = |(edgecap_q & irqmask_q);
  end

  assign bus.readdata = readdata_q;
  assign irq          = irq_q;

endmodule : button_edge_irq_ctrl

// File: tb/tb_button_edge_irq_ctrl.sv
// Directed self-checking bench for button_edge_irq_ctrl with
// WIDTH=4, DEBOUNCE_CYCLES=4, IDLE_LEVEL=1. Inputs change and outputs
// are sampled on the falling clock edge.
module tb_button_edge_irq_ctrl;

  logic       clk;
  logic       reset_n;
  logic [3:0] in_port;
  logic       irq;
  logic [31:0] rdata;
  int         assertCount;
  int         failCount;

  button_edge_irq_ctrl_if bus ();

  button_edge_irq_ctrl #(
    .WIDTH           (4),
    .DEBOUNCE_CYCLES (4),
    .IDLE_LEVEL      (1'b1)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .in_port (in_port),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [3:0] keys);
    in_port = keys;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic busWrite(input logic [1:0] addr, input logic [31:0] data);
    bus.address    = addr;
    bus.writedata  = data;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic busRead(input logic [1:0] addr, output logic [31:0] data);
    bus.address    = addr;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    @(negedge clk);
    data           = bus.readdata;
    bus.chipselect = 1'b0;
  endtask

  initial begin
    assertCount    = 0;
    failCount      = 0;
    reset_n        = 1'b0;
    in_port        = 4'hF;
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;

    // Reset and idle
    tick(3);
    checkOutput("reset_readdata", bus.readdata, 32'h0);
    checkOutput("reset_irq", {31'b0, irq}, 32'h0);
    reset_n = 1'b1;
    tick(1);
    busRead(2'd0, rdata); checkOutput("idle_data", rdata, 32'hF);
    busRead(2'd1, rdata); checkOutput("idle_irqmask", rdata, 32'h0);
    busRead(2'd2, rdata); checkOutput("idle_edgecap", rdata, 32'h0);
    busRead(2'd3, rdata); checkOutput("idle_mode", rdata, 32'h1);
    checkOutput("idle_irq", {31'b0, irq}, 32'h0);

    // Clean press on button 2: stable flips on the 6th edge
    busWrite(2'd1, 32'h4);
    bus.address = 2'd0;
    applyStimulus(4'hB);
    tick(5); checkOutput("press_data_c5", bus.readdata, 32'hF);
    tick(1); checkOutput("press_data_c6", bus.readdata, 32'hF);
    tick(1); checkOutput("press_data_c7", bus.readdata, 32'hB);
    checkOutput("press_irq_c7", {31'b0, irq}, 32'h0);
    tick(1); checkOutput("press_irq_c8", {31'b0, irq}, 32'h1);
    busRead(2'd2, rdata); checkOutput("press_edgecap", rdata, 32'h4);

    // Glitch on button 0 shorter than the debounce window
    applyStimulus(4'hA);
    tick(3);
    applyStimulus(4'hB);
    tick(10);
    busRead(2'd0, rdata); checkOutput("glitch_data", rdata, 32'hB);
    busRead(2'd2, rdata); checkOutput("glitch_edgecap", rdata, 32'h4);

    // W1C clear, irq falls one cycle after the write
    busWrite(2'd2, 32'h4);
    checkOutput("w1c_irq_same", {31'b0, irq}, 32'h1);
    tick(1);
    checkOutput("w1c_irq_after", {31'b0, irq}, 32'h0);
    busRead(2'd2, rdata); checkOutput("w1c_edgecap", rdata, 32'h0);

    // Release button 2 (not captured in press mode), then race a clear with a new press
    applyStimulus(4'hF);
    tick(10);
    busRead(2'd2, rdata); checkOutput("rel_not_captured", rdata, 32'h0);
    applyStimulus(4'hB);
    tick(6);
    busWrite(2'd2, 32'h4);
    busRead(2'd2, rdata); checkOutput("race_edgecap", rdata, 32'h4);
    checkOutput("race_irq", {31'b0, irq}, 32'h1);

    // Masking write drops irq one cycle later
    busWrite(2'd1, 32'h0);
    checkOutput("mask_irq_same", {31'b0, irq}, 32'h1);
    tick(1);
    checkOutput("mask_irq_after", {31'b0, irq}, 32'h0);
    busWrite(2'd2, 32'hF);

    // Release-only mode on button 0
    busWrite(2'd3, 32'h2);
    busWrite(2'd1, 32'h1);
    busRead(2'd3, rdata); checkOutput("mode_readback", rdata, 32'h2);
    applyStimulus(4'hA);
    tick(10);
    busRead(2'd2, rdata); checkOutput("relmode_press", rdata, 32'h0);
    checkOutput("relmode_press_irq", {31'b0, irq}, 32'h0);
    applyStimulus(4'hB);
    tick(10);
    busRead(2'd2, rdata); checkOutput("relmode_release", rdata, 32'h1);
    checkOutput("relmode_release_irq", {31'b0, irq}, 32'h1);
    busWrite(2'd0, 32'h0);
    busRead(2'd0, rdata); checkOutput("data_write_ignored", rdata, 32'hB);

    // Async reset two cycles into a button-1 debounce
    bus.address = 2'd0;
    applyStimulus(4'hD);
    tick(4);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("midreset_readdata", bus.readdata, 32'h0);
    checkOutput("midreset_irq", {31'b0, irq}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    tick(6); checkOutput("postreset_data_c6", bus.readdata, 32'hF);
    tick(1); checkOutput("postreset_data_c7", bus.readdata, 32'hD);
    busRead(2'd2, rdata); checkOutput("postreset_edgecap", rdata, 32'h2);
    busRead(2'd3, rdata); checkOutput("postreset_mode", rdata, 32'h1);
    busRead(2'd1, rdata); checkOutput("postreset_irqmask", rdata, 32'h0);
    checkOutput("postreset_irq", {31'b0, irq}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule : tb_button_edge_irq_ctrl
